dmux_stream: RTL and testbench

DMUX_STREAM -- requirements
Module: dmux_stream

---
 rtl/dmux_stream_pkg.sv | 14 +
 rtl/dmux_slot.sv | 54 +++++
 rtl/dmux_stream.sv | 83 ++++++++
 tb/tb_dmux_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared constants and types for the two-way stream demultiplexer.
package dmux_stream_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/dmux_slot.sv
// One-entry output slot with valid/ready handshake; accepts a load in the same
// cycle it drains, so a continuously ready sink sees one word per cycle.
//
// state | meaning
// EMPTY | no word held, valid low
// FULL  | word held on data_out, valid high until the sink takes it
module dmux_slot
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             can_load
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_ok;
    logic             drain;

    assign can_load = (state_q == EMPTY) || ready;
    assign load_ok  = load && can_load;
    assign drain    = (state_q == FULL) && ready;
    assign valid    = (state_q == FULL);
    assign data_out = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_ok) begin
            state_d = FULL;
            data_d  = data_in;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// Routes one input stream to output A or B by in_sel; each output has its own slot.
// Define DMUX_STREAM_COUNT_EN to add the cnt_a/cnt_b delivered-word counters.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    output logic                 outa_valid,
    input  logic                 outa_ready,
    output logic [WIDTH-1:0]     outa_data,
    output logic                 outb_valid,
    input  logic                 outb_ready,
    output logic [WIDTH-1:0]     outb_data
`ifdef DMUX_STREAM_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
`endif
);

    logic can_load_a, can_load_b;
    logic load_a, load_b;

    // in_ready looks only at the selected slot, never at in_valid.
    assign in_ready = !reset && ((in_sel == SEL_B) ? can_load_b : can_load_a);
    assign load_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign load_b   = in_valid && in_ready && (in_sel == SEL_B);

    dmux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load_a),
        .data_in  (in_data),
        .ready    (outa_ready),
        .valid    (outa_valid),
        .data_out (outa_data),
        .can_load (can_load_a)
    );

    dmux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load_b),
        .data_in  (in_data),
        .ready    (outb_ready),
        .valid    (outb_valid),
        .data_out (outb_data),
        .can_load (can_load_b)
    );

`ifdef DMUX_STREAM_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (outa_valid && outa_ready) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
        if (outb_valid && outb_ready) cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream: directed scenarios plus randomized traffic
// against a per-output queue model.
module tb_dmux_stream;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          outa_valid, outa_ready;
    logic [W-1:0]  outa_data;
    logic          outb_valid, outb_ready;
    logic [W-1:0]  outb_data;
`ifdef DMUX_STREAM_COUNT_EN
    logic [CW-1:0] cnt_a, cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    dmux_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .outa_valid (outa_valid),
        .outa_ready (outa_ready),
        .outa_data  (outa_data),
        .outb_valid (outb_valid),
        .outb_ready (outb_ready),
        .outb_data  (outb_data)
`ifdef DMUX_STREAM_COUNT_EN
        ,
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        #3;
        chk("reset_outa_valid", {15'b0, outa_valid}, 16'h0);
        chk("reset_outb_valid", {15'b0, outb_valid}, 16'h0);
        chk("reset_outa_data", outa_data, 16'h0);
        chk("reset_outb_data", outb_data, 16'h0);
        chk("reset_in_ready_a", {15'b0, in_ready}, 16'h0);
        in_sel = 1'b1;
        #1;
        chk("reset_in_ready_b", {15'b0, in_ready}, 16'h0);
        tick();
        chk("reset_offer_discarded", {14'b0, outa_valid, outb_valid}, 16'h0);
`ifdef DMUX_STREAM_COUNT_EN
        chk("reset_cnt_a", {12'b0, cnt_a}, 16'h0);
        chk("reset_cnt_b", {12'b0, cnt_b}, 16'h0);
`endif
        drive(1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        drive(1'b1, 1'b0, 16'hBEEF);
        #1;
        chk("basic_in_ready", {15'b0, in_ready}, 16'h1);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        chk("basic_outa_valid", {15'b0, outa_valid}, 16'h1);
        chk("basic_outa_data", outa_data, 16'hBEEF);
        chk("basic_outb_valid", {15'b0, outb_valid}, 16'h0);
        tick();
        chk("basic_outa_drained", {15'b0, outa_valid}, 16'h0);
    endtask

    task automatic test_stall();
        outa_ready = 1'b1;
        outb_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h0001);
        tick();
        chk("stall_outb_valid", {15'b0, outb_valid}, 16'h1);
        chk("stall_outb_data", outb_data, 16'h0001);
        drive(1'b1, 1'b1, 16'h0055);
        #1;
        chk("stall_in_ready_b", {15'b0, in_ready}, 16'h0);
        tick();
        chk("stall_outb_held", outb_data, 16'h0001);
        drive(1'b1, 1'b0, 16'h0002);
        #1;
        chk("stall_in_ready_a", {15'b0, in_ready}, 16'h1);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        chk("stall_outa_valid", {15'b0, outa_valid}, 16'h1);
        chk("stall_outa_data", outa_data, 16'h0002);
        chk("stall_outb_still", outb_data, 16'h0001);
        chk("stall_outb_still_valid", {15'b0, outb_valid}, 16'h1);
        outb_ready = 1'b1;
        tick();
        tick();
        chk("stall_drained", {14'b0, outa_valid, outb_valid}, 16'h0);
    endtask

    task automatic test_back_to_back();
        outb_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h000F);
        tick();
        outb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h0010 + 16'(i));
            #1;
            chk("b2b_in_ready", {15'b0, in_ready}, 16'h1);
            tick();
            chk("b2b_outb_valid", {15'b0, outb_valid}, 16'h1);
            chk("b2b_outb_data", outb_data, 16'h0010 + 16'(i));
        end
        drive(1'b0, 1'b0, 16'h0);
        tick();
        chk("b2b_empty", {15'b0, outb_valid}, 16'h0);
    endtask

    task automatic test_async_reset();
        outa_ready = 1'b0;
        outb_ready = 1'b0;
        drive(1'b1, 1'b0, 16'hAAAA);
        tick();
        drive(1'b1, 1'b1, 16'hBBBB);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        chk("areset_pre_full", {14'b0, outa_valid, outb_valid}, 16'h3);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("areset_outa_valid", {15'b0, outa_valid}, 16'h0);
        chk("areset_outb_valid", {15'b0, outb_valid}, 16'h0);
        chk("areset_data", outa_data | outb_data, 16'h0);
        tick();
        reset = 1'b0;
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("areset_no_delivery", {14'b0, outa_valid, outb_valid}, 16'h0);
        end
    endtask

`ifdef DMUX_STREAM_COUNT_EN
    task automatic test_count();
        do_reset();
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            tick();
        end
        drive(1'b0, 1'b0, 16'h0);
        tick();
        tick();
        chk("count_cnt_a_wrap", {12'b0, cnt_a}, 16'h1);
        chk("count_cnt_b", {12'b0, cnt_b}, 16'h0);
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         exp_ready;
        int           sent_a = 0;
        int           sent_b = 0;
        do_reset();
        for (int cyc = 0; cyc < 10000 + 4; cyc++) begin
            if (cyc < 10000) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
                outa_ready = ($urandom_range(0, 3) != 0);
                outb_ready = ($urandom_range(0, 3) != 0);
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
                outa_ready = 1'b1;
                outb_ready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (outa_valid !== (qa.size() != 0)) begin
                errors++;
                $display("FAIL rand_outa_valid: got %b expected %b cycle %0d", outa_valid, qa.size() != 0, cyc);
            end
            checks++;
            if (outb_valid !== (qb.size() != 0)) begin
                errors++;
                $display("FAIL rand_outb_valid: got %b expected %b cycle %0d", outb_valid, qb.size() != 0, cyc);
            end
            if (qa.size() != 0) begin
                checks++;
                if (outa_data !== qa[0]) begin
                    errors++;
                    $display("FAIL rand_outa_data: got %h expected %h cycle %0d", outa_data, qa[0], cyc);
                end
            end
            if (qb.size() != 0) begin
                checks++;
                if (outb_data !== qb[0]) begin
                    errors++;
                    $display("FAIL rand_outb_data: got %h expected %h cycle %0d", outb_data, qb[0], cyc);
                end
            end
            exp_ready = in_sel ? (qb.size() == 0 || outb_ready) : (qa.size() == 0 || outa_ready);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_in_ready: got %b expected %b cycle %0d", in_ready, exp_ready, cyc);
            end
            if (qa.size() != 0 && outa_ready) begin
                void'(qa.pop_front());
                sent_a++;
            end
            if (qb.size() != 0 && outb_ready) begin
                void'(qb.pop_front());
                sent_b++;
            end
            if (in_valid && exp_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL rand_undelivered: got %0d/%0d expected 0/0", qa.size(), qb.size());
        end
`ifdef DMUX_STREAM_COUNT_EN
        chk("rand_cnt_a", {12'b0, cnt_a}, 16'(sent_a % 16));
        chk("rand_cnt_b", {12'b0, cnt_b}, 16'(sent_b % 16));
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_async_reset();
`ifdef DMUX_STREAM_COUNT_EN
        test_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
